// File: rtl/counter_bank.sv
// counter_bank: bank of NUM_CH independent countdown timers (service desks).
// An accepted request (customer number + service time) is placed on the
// lowest-index idle channel. The timers count down on the shared tick strobe.
// The bank reports one-cycle completion pulses and a saturating served total.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   tick           one-cycle time-base strobe
//   pause          level; freezes countdown and completion while high
//   req_valid      request present
//   req_num        customer number of the request
//   req_time       service time of the request, in ticks (0 is loaded as 1)
//   req_ready      at least one channel idle (from registered busy only)
//   grant_ch       lowest idle channel, 0 when none is idle
//   cancel_valid   abort the channel selected by cancel_ch this cycle
//   cancel_ch      channel to abort (ignored if idle or out of range)
//   busy           per-channel busy flags
//   num_out        per-channel customer number, channel i at [i*NUM_W +: NUM_W]
//   rem_out        per-channel remaining ticks, channel i at [i*TIME_W +: TIME_W]
//   done_mask      one-cycle pulse per channel completing normally
//   served         customers completed since reset, saturating
module counter_bank #(
  parameter int NUM_CH = 4,
  parameter int NUM_W  = 4,
  parameter int TIME_W = 4,
  parameter int CNT_W  = 8,
  localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     pause,
  input  logic                     req_valid,
  input  logic [NUM_W-1:0]         req_num,
  input  logic [TIME_W-1:0]        req_time,
  output logic                     req_ready,
  output logic [CH_W-1:0]          grant_ch,
  input  logic                     cancel_valid,
  input  logic [CH_W-1:0]          cancel_ch,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH*NUM_W-1:0]  num_out,
  output logic [NUM_CH*TIME_W-1:0] rem_out,
  output logic [NUM_CH-1:0]        done_mask,
  output logic [CNT_W-1:0]         served
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [TIME_W-1:0] ONE_T   = TIME_W'(1);

  function automatic int unsigned popcount(input logic [NUM_CH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Saturating add: the served total sticks at its maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input int unsigned b);
    longint unsigned sum;
    sum = longint'(a) + longint'(b);
    if (sum > longint'(CNT_MAX)) return CNT_MAX;
    return CNT_W'(sum);
  endfunction

  logic [NUM_CH-1:0]        busy_nxt;
  logic [NUM_CH-1:0]        done_nxt;
  logic [NUM_CH-1:0]        cancel_hit;
  logic [NUM_CH*NUM_W-1:0]  num_nxt;
  logic [NUM_CH*TIME_W-1:0] rem_nxt;
  logic [CNT_W-1:0]         served_nxt;
  logic                     accept;
  logic                     count_en;
  logic [TIME_W-1:0]        load_time;
  logic [TIME_W-1:0]        rem_i;

  // Descending scan so the last assignment wins: the lowest idle index.
  always_comb begin
    grant_ch  = '0;
    req_ready = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        grant_ch  = CH_W'(i);
        req_ready = 1'b1;
      end
    end
  end

  // Next-state per channel. Priority per channel: cancel, then countdown or
  // completion, then load. Only a channel idle at cycle start can be loaded.
  // So a channel freed this cycle is reused next cycle at the earliest, and a
  // freshly loaded channel is never decremented on its load edge.
  always_comb begin
    accept     = req_valid && req_ready;
    count_en   = tick && !pause;
    load_time  = (req_time == '0) ? ONE_T : req_time;
    busy_nxt   = busy;
    num_nxt    = num_out;
    rem_nxt    = rem_out;
    done_nxt   = '0;
    cancel_hit = '0;
    rem_i      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rem_i         = rem_out[i*TIME_W +: TIME_W];
      cancel_hit[i] = cancel_valid && (cancel_ch == CH_W'(i)) && busy[i];
      if (cancel_hit[i]) begin
        busy_nxt[i]                = 1'b0;
        num_nxt[i*NUM_W +: NUM_W]  = '0;
        rem_nxt[i*TIME_W +: TIME_W] = '0;
      end else if (busy[i] && count_en) begin
        if (rem_i <= ONE_T) begin
          busy_nxt[i]                 = 1'b0;
          num_nxt[i*NUM_W +: NUM_W]   = '0;
          rem_nxt[i*TIME_W +: TIME_W] = '0;
          done_nxt[i]                 = 1'b1;
        end else begin
          rem_nxt[i*TIME_W +: TIME_W] = rem_i - ONE_T;
        end
      end else if (!busy[i] && accept && (grant_ch == CH_W'(i))) begin
        busy_nxt[i]                 = 1'b1;
        num_nxt[i*NUM_W +: NUM_W]   = req_num;
        rem_nxt[i*TIME_W +: TIME_W] = load_time;
      end
    end
    served_nxt = sat_add(served, popcount(done_nxt));
  end

  // State register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      num_out   <= '0;
      rem_out   <= '0;
      done_mask <= '0;
      served    <= '0;
    end else begin
      busy      <= busy_nxt;
      num_out   <= num_nxt;
      rem_out   <= rem_nxt;
      done_mask <= done_nxt;
      served    <= served_nxt;
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, pause, req_valid, cancel_valid;
  logic [3:0]  req_num, req_time;
  logic [1:0]  cancel_ch;

  logic        req_ready, req_ready2;
  logic [1:0]  grant_ch, grant_ch2;
  logic [3:0]  busy, busy2, done_mask, done_mask2;
  logic [15:0] num_out, num_out2, rem_out, rem_out2;
  logic [7:0]  served;
  logic [1:0]  served2;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_sat [5];

  always #5 clk = ~clk;

  counter_bank dut (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause),
    .req_valid(req_valid), .req_num(req_num), .req_time(req_time),
    .req_ready(req_ready), .grant_ch(grant_ch),
    .cancel_valid(cancel_valid), .cancel_ch(cancel_ch),
    .busy(busy), .num_out(num_out), .rem_out(rem_out),
    .done_mask(done_mask), .served(served)
  );

  counter_bank #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause),
    .req_valid(req_valid), .req_num(req_num), .req_time(req_time),
    .req_ready(req_ready2), .grant_ch(grant_ch2),
    .cancel_valid(cancel_valid), .cancel_ch(cancel_ch),
    .busy(busy2), .num_out(num_out2), .rem_out(rem_out2),
    .done_mask(done_mask2), .served(served2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [3:0] n, input logic [3:0] t);
    req_valid = 1'b1; req_num = n; req_time = t;
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; tick = 1'b0; pause = 1'b0; req_valid = 1'b0; req_num = '0;
    req_time = '0; cancel_valid = 1'b0; cancel_ch = '0;
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_num", 32'(num_out), 32'h0);
    chk("rst_rem", 32'(rem_out), 32'h0);
    chk("rst_done", 32'(done_mask), 32'h0);
    chk("rst_served", 32'(served), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_grant", 32'(grant_ch), 32'h0);
    rst = 1'b0;
    cyc();

    // 1: single customer, time 3, ticks spaced 4 cycles
    request(4'd5, 4'd3);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_num", 32'(num_out), 32'h5);
    chk("t1_rem3", 32'(rem_out), 32'h3);
    chk("t1_grant", 32'(grant_ch), 32'h1);
    repeat (3) cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t1_rem2", 32'(rem_out), 32'h2);
    repeat (3) cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t1_rem1", 32'(rem_out), 32'h1);
    chk("t1_nodone", 32'(done_mask), 32'h0);
    repeat (3) cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_done", 32'(done_mask), 32'h1);
    chk("t1_served", 32'(served), 32'h1);
    chk("t1_clr", 32'(num_out), 32'h0);
    cyc();
    chk("t1_done_gone", 32'(done_mask), 32'h0);
    chk("t1_served_hold", 32'(served), 32'h1);

    // 2: fill all four channels, fifth request refused
    for (int k = 1; k <= 4; k++) begin
      chk("t2_grant", 32'(grant_ch), 32'(k - 1));
      chk("t2_ready", 32'(req_ready), 32'h1);
      request(4'(k), 4'd2);
    end
    req_valid = 1'b1; req_num = 4'd9; req_time = 4'd7;
    chk("t2_full_ready", 32'(req_ready), 32'h0);
    chk("t2_full_grant", 32'(grant_ch), 32'h0);
    cyc();
    req_valid = 1'b0;
    chk("t2_busy", 32'(busy), 32'hF);
    chk("t2_nums", 32'(num_out), 32'h4321);
    chk("t2_rems", 32'(rem_out), 32'h2222);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t2_rem1", 32'(rem_out), 32'h1111);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t2_done", 32'(done_mask), 32'hF);
    chk("t2_served", 32'(served), 32'h5);
    chk("t2_idle", 32'(busy), 32'h0);
    cyc();
    chk("t2_done_gone", 32'(done_mask), 32'h0);

    // 3: cancel beats completion on the same tick
    request(4'd7, 4'd5);
    request(4'd8, 4'd1);
    chk("t3_rems", 32'(rem_out), 32'h15);
    cancel_valid = 1'b1; cancel_ch = 2'd1; tick = 1'b1;
    cyc();
    cancel_valid = 1'b0; tick = 1'b0;
    chk("t3_busy", 32'(busy), 32'h1);
    chk("t3_rem", 32'(rem_out), 32'h4);
    chk("t3_nodone", 32'(done_mask), 32'h0);
    chk("t3_served", 32'(served), 32'h5);
    cancel_valid = 1'b1; cancel_ch = 2'd2;
    cyc();
    chk("t3_idle_cancel", 32'(busy), 32'h1);
    cancel_ch = 2'd0;
    cyc();
    cancel_valid = 1'b0;
    chk("t3_cancel0", 32'(busy), 32'h0);
    chk("t3_cancel0_num", 32'(num_out), 32'h0);

    // 4: pause freezes countdown, accept still works
    request(4'd3, 4'd2);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    chk("t4_frozen", 32'(rem_out), 32'h2);
    chk("t4_nodone", 32'(done_mask), 32'h0);
    tick = 1'b1;
    request(4'd6, 4'd4);
    tick = 1'b0;
    chk("t4_busy", 32'(busy), 32'h3);
    chk("t4_rems", 32'(rem_out), 32'h42);
    chk("t4_nums", 32'(num_out), 32'h63);
    pause = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t4_run", 32'(rem_out), 32'h31);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t4_done", 32'(done_mask), 32'h1);
    chk("t4_busy2", 32'(busy), 32'h2);
    chk("t4_served", 32'(served), 32'h6);
    cancel_valid = 1'b1; cancel_ch = 2'd1;
    cyc();
    cancel_valid = 1'b0;
    chk("t4_clean", 32'(busy), 32'h0);

    // 5: time 0 loads as 1, tick on the load edge does not decrement
    tick = 1'b1;
    request(4'd2, 4'd0);
    tick = 1'b0;
    chk("t5_rem", 32'(rem_out), 32'h1);
    chk("t5_busy", 32'(busy), 32'h1);
    chk("t5_nodone", 32'(done_mask), 32'h0);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t5_done", 32'(done_mask), 32'h1);
    chk("t5_served", 32'(served), 32'h7);
    chk("t5_idle", 32'(busy), 32'h0);

    // 6: saturating served counter, then asynchronous reset mid-service
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    chk("t6_served_rst", 32'(served), 32'h0);
    for (int k = 0; k < 5; k++) begin
      request(4'(k + 1), 4'd1);
      tick = 1'b1; cyc(); tick = 1'b0;
      chk("t6_sat", 32'(served2), 32'(exp_sat[k]));
      chk("t6_wide", 32'(served), 32'(k + 1));
    end
    request(4'd9, 4'd5);
    chk("t6_loaded", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_arst_busy", 32'(busy), 32'h0);
    chk("t6_arst_num", 32'(num_out), 32'h0);
    chk("t6_arst_rem", 32'(rem_out), 32'h0);
    chk("t6_arst_done", 32'(done_mask), 32'h0);
    chk("t6_arst_served", 32'(served), 32'h0);
    chk("t6_arst_served2", 32'(served2), 32'h0);
    chk("t6_arst_busy2", 32'(busy2), 32'h0);
    #1;
    rst = 1'b0;
    cyc();
    chk("t6_after_busy", 32'(busy), 32'h0);
    chk("t6_after_done", 32'(done_mask), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
